// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb
// Round-robin arbiter that lets N requesters share the write side of one FIFO.
// One requester at a time owns the FIFO tail. An owner keeps the grant for up
// to BURST pushes, or until it drops valid. Every new grant costs one idle
// cycle for arbitration.
//
// Optional feature: define FIFO_WR_ARB_BURST_EN to enable multi-beat bursts.
// When it is undefined, every grant lasts exactly one push, no beat counter is
// built, and BURST has no effect.
//
// Ports:
//   clk          single clock
//   rst          asynchronous active-high reset
//   req_valid    [N]   requester i has an item
//   req_data     [N]   item offered by requester i (unpacked array)
//   req_ready    [N]   requester i's item is taken this cycle (valid & ready)
//   tail               data to the shared FIFO
//   push               FIFO write strobe
//   full               FIFO full
//   wr_rst_busy        FIFO write-side reset in progress
//   grant        [N]   one-hot current owner, zero when nobody owns
//   grant_idx          binary index of the owner, zero when nobody owns
module fifo_wr_arb #(
  parameter type DATA_ITEM_TYPE = logic,
  parameter int  N              = 4,
  parameter int  BURST          = 4,
  localparam int IDX_W          = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  DATA_ITEM_TYPE        req_data [N],
  output logic [N-1:0]         req_ready,
  output DATA_ITEM_TYPE        tail,
  output logic                 push,
  input  logic                 full,
  input  logic                 wr_rst_busy,
  output logic [N-1:0]         grant,
  output logic [IDX_W-1:0]     grant_idx
);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_OWN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             owner_valid;

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
`endif

  assign owner_valid = req_valid[owner_q];

  // Round-robin search: first set valid bit starting just above the last
  // winner, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last_q) + k) % N);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Output side: only the owner sees ready, and the push is combinational so
  // a full or resetting FIFO blocks the beat in the same cycle.
  always_comb begin
    req_ready = '0;
    push      = 1'b0;
    tail      = req_data[0];
    grant     = '0;
    grant_idx = '0;
    if (state_q == ST_OWN) begin
      req_ready[owner_q] = ~full & ~wr_rst_busy;
      push               = owner_valid & ~full & ~wr_rst_busy;
      tail               = req_data[owner_q];
      grant[owner_q]     = 1'b1;
      grant_idx          = owner_q;
    end
  end

  // Next-state logic. A FIFO write-side reset always wins and throws away
  // the current burst, but the round-robin pointer survives it.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef FIFO_WR_ARB_BURST_EN
    beat_cnt_d = beat_cnt_q;
`endif
    case (state_q)
      ST_WAIT: begin
        if (!wr_rst_busy) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (wr_rst_busy) begin
          state_d = ST_WAIT;
        end else if (win_found) begin
          state_d = ST_OWN;
          owner_d = win_idx;
          last_d  = win_idx;
`ifdef FIFO_WR_ARB_BURST_EN
          beat_cnt_d = '0;
`endif
        end
      end
      ST_OWN: begin
        if (wr_rst_busy) begin
          state_d = ST_WAIT;
        end else if (!owner_valid) begin
          state_d = ST_IDLE;
        end else if (push) begin
`ifdef FIFO_WR_ARB_BURST_EN
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == CNT_W'(BURST - 1)) state_d = ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // State registers. last resets to N-1 so requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT;
      owner_q <= '0;
      last_q  <= IDX_W'(N - 1);
`ifdef FIFO_WR_ARB_BURST_EN
      beat_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef FIFO_WR_ARB_BURST_EN
      beat_cnt_q <= beat_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Testbench for fifo_wr_arb with N=4, BURST=4 and 8-bit items.
// Each item carries {requester index, per-requester sequence number}, so the
// scoreboard can tell both which requester pushed and which of its items.
// The effective burst length follows FIFO_WR_ARB_BURST_EN (4 when defined,
// 1 otherwise).
module tb_fifo_wr_arb;

  localparam int N = 4;
`ifdef FIFO_WR_ARB_BURST_EN
  localparam int EB = 4;
`else
  localparam int EB = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [7:0]  req_data [N];
  logic [3:0]  req_ready;
  logic [7:0]  tail;
  logic        push;
  logic        full;
  logic        wr_rst_busy;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q [$];
  logic [5:0] seq     [N] = '{default: 6'd0};
  logic [5:0] exp_seq [N] = '{default: 6'd0};
  logic [3:0] acc = 4'b0000;

  fifo_wr_arb #(
    .DATA_ITEM_TYPE(logic [7:0]),
    .N(N),
    .BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tail(tail),
    .push(push),
    .full(full),
    .wr_rst_busy(wr_rst_busy),
    .grant(grant),
    .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i] = {2'(i), seq[i]};
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) if (acc[i]) seq[i] <= seq[i] + 6'd1;
  end

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [7:0] e;
    logic [3:0] g_exp;
    acc = req_valid & req_ready;
    total++;
    if ($countones(req_ready) > 1 || (push && full) || (push !== (|acc))) begin
      bad++;
      $display("[TB] FAIL protocol push=%b full=%b ready=%b valid=%b", push, full, req_ready, req_valid);
    end
    if (push) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_push tail=%h grant=%b required no push", tail, grant);
      end else begin
        e = exp_q.pop_front();
        g_exp = 4'b0001 << e[7:6];
        if (tail !== e || grant_idx !== e[7:6] || grant !== g_exp) begin
          bad++;
          $display("[TB] FAIL beat tail=%h idx=%0d grant=%b required tail=%h idx=%0d grant=%b",
                   tail, grant_idx, grant, e, e[7:6], g_exp);
        end
      end
    end
  end

  task automatic expect_beats(input logic [1:0] idx, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({idx, exp_seq[idx]});
      exp_seq[idx] = exp_seq[idx] + 6'd1;
    end
  endtask

  task automatic do_reset(input logic [3:0] v, input logic busy);
    rst = 1'b1; req_valid = 4'b0000; full = 1'b0; wr_rst_busy = busy;
    repeat (2) @(posedge clk);
    #1;
    req_valid = v;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output int cycles, output bit ok);
    cycles = 0; ok = 1'b0;
    while (!ok && cycles < budget) begin
      @(posedge clk); #1; cycles++;
      if (exp_q.size() == 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; full = 1'b0; wr_rst_busy = 1'b0;
    #1;
    total++;
    if (push !== 1'b0 || req_ready !== 4'b0 || grant !== 4'b0 || grant_idx !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_async push=%b ready=%b grant=%b idx=%0d required all zero", push, req_ready, grant, grant_idx);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (push !== 1'b0 || req_ready !== 4'b0 || grant !== 4'b0 || grant_idx !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_hold push=%b ready=%b grant=%b idx=%0d required all zero", push, req_ready, grant, grant_idx);
    end
  endtask

  task automatic test_wait_release();
    int cycles; bit ok;
    do_reset(4'b1111, 1'b1);
    repeat (5) begin
      @(negedge clk);
      total++;
      if (push !== 1'b0 || grant !== 4'b0) begin
        bad++;
        $display("[TB] FAIL wait_hold push=%b grant=%b required 0 0", push, grant);
      end
      @(posedge clk);
    end
    #1 wr_rst_busy = 1'b0;
    expect_beats(2'd0, EB); expect_beats(2'd1, EB); expect_beats(2'd2, EB);
    expect_beats(2'd3, EB); expect_beats(2'd0, EB);
    @(negedge clk);
    total++;
    if (push !== 1'b0 || grant !== 4'b0) begin
      bad++;
      $display("[TB] FAIL wait_exit push=%b grant=%b required 0 0", push, grant);
    end
    @(negedge clk);
    total++;
    if (push !== 1'b0 || grant !== 4'b0) begin
      bad++;
      $display("[TB] FAIL idle_bubble push=%b grant=%b required 0 0", push, grant);
    end
    @(negedge clk);
    total++;
    if (push !== 1'b1 || grant !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL first_owner push=%b grant=%b required 1 0001", push, grant);
    end
    wait_drain(200, cycles, ok);
    req_valid = 4'b0000;
    total++;
    if (!ok || cycles != 5 * EB + 4) begin
      bad++;
      $display("[TB] FAIL rotation_cycles drained=%b cycles=%0d required 1 %0d", ok, cycles, 5 * EB + 4);
    end
  endtask

  task automatic test_alternate();
    int cycles; bit ok;
    do_reset(4'b1010, 1'b0);
    expect_beats(2'd1, EB); expect_beats(2'd3, EB);
    expect_beats(2'd1, EB); expect_beats(2'd3, EB);
    wait_drain(200, cycles, ok);
    req_valid = 4'b0000;
    total++;
    if (!ok || cycles != 4 * EB + 5) begin
      bad++;
      $display("[TB] FAIL alternate_cycles drained=%b cycles=%0d required 1 %0d", ok, cycles, 4 * EB + 5);
    end
  endtask

  task automatic test_full_stall();
    int cycles; bit ok; int n;
    logic [5:0] base;
    int target;
    target = (EB >= 3) ? 2 : 0;
    do_reset(4'b0100, 1'b0);
    base = exp_seq[2];
    expect_beats(2'd2, EB);
    n = 0;
    while (!(seq[2] == base + 6'(target) && grant[2]) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("[TB] FAIL stall_setup beats=%0d required %0d", seq[2] - base, target);
    end
    full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (push !== 1'b0 || req_ready !== 4'b0 || grant !== 4'b0100) begin
        bad++;
        $display("[TB] FAIL full_hold push=%b ready=%b grant=%b required 0 0000 0100", push, req_ready, grant);
      end
      @(posedge clk);
    end
    #1 full = 1'b0;
    wait_drain(100, cycles, ok);
    req_valid = 4'b0000;
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL stall_resume left=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_drop_valid();
    int cycles; bit ok; int n;
    logic [5:0] base;
    logic [3:0] g_exp;
    g_exp = (EB > 1) ? 4'b0001 : 4'b0000;
    do_reset(4'b0011, 1'b0);
    base = exp_seq[0];
    expect_beats(2'd0, 1); expect_beats(2'd1, EB);
    n = 0;
    while (seq[0] != base + 6'd1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 4'b0010;
    @(negedge clk);
    total++;
    if (n >= 50 || push !== 1'b0 || grant !== g_exp) begin
      bad++;
      $display("[TB] FAIL drop_valid push=%b grant=%b required 0 %b", push, grant, g_exp);
    end
    wait_drain(100, cycles, ok);
    req_valid = 4'b0000;
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL drop_next_owner left=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_busy_pulse();
    int cycles; bit ok; int n;
    logic [5:0] base;
    do_reset(4'b1000, 1'b0);
    base = exp_seq[3];
    expect_beats(2'd3, 1);
    n = 0;
    while (!(seq[3] == base + 6'd1 && grant[3]) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    wr_rst_busy = 1'b1;
    @(negedge clk);
    total++;
    if (n >= 50 || push !== 1'b0 || req_ready !== 4'b0) begin
      bad++;
      $display("[TB] FAIL busy_blocks push=%b ready=%b required 0 0000", push, req_ready);
    end
    @(posedge clk); #1;
    wr_rst_busy = 1'b0;
    req_valid = 4'b1001;
    @(negedge clk);
    total++;
    if (push !== 1'b0 || grant !== 4'b0) begin
      bad++;
      $display("[TB] FAIL busy_to_wait push=%b grant=%b required 0 0000", push, grant);
    end
    expect_beats(2'd0, EB); expect_beats(2'd3, EB);
    wait_drain(100, cycles, ok);
    req_valid = 4'b0000;
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL busy_recover left=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_rst_mid_burst();
    int n;
    logic [5:0] base;
    do_reset(4'b0010, 1'b0);
    base = exp_seq[1];
    expect_beats(2'd1, 1);
    n = 0;
    while (!(seq[1] == base + 6'd1 && grant[1]) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    rst = 1'b1;
    #1;
    total++;
    if (n >= 50 || push !== 1'b0 || req_ready !== 4'b0 || grant !== 4'b0) begin
      bad++;
      $display("[TB] FAIL async_abort push=%b ready=%b grant=%b required 0 0000 0000", push, req_ready, grant);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL abort_leftover left=%0d required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] fifo_wr_arb bench, effective burst %0d", EB);
    test_reset();
    test_wait_release();
    test_alternate();
    test_full_stall();
    test_drop_valid();
    test_busy_pulse();
    test_rst_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
